// File: rtl/dbg_instr_encoder_pkg.sv
// Shared types and constants for the debug abstract-command instruction encoder.
// Holds the command record, the sequencer states and RV32 system-opcode fields.
package dbg_instr_encoder_pkg;

    typedef struct packed {
        logic [15:0] regno;
        logic        write;
        logic        transfer;
        logic        postexec;
        logic [2:0]  aarsize;
    } dbg_cmd_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FIN  = 2'd2
    } enc_state_type;

    localparam logic [11:0] csr_dscratch0  = 12'h7B2;
    localparam logic [11:0] csr_dscratch1  = 12'h7B3;
    localparam logic [4:0]  tmp_gpr        = 5'd8;
    localparam logic [31:0] ebreak_instr   = 32'h0010_0073;
    localparam logic [6:0]  opcode_system  = 7'b1110011;
    localparam logic [2:0]  funct_csrrw    = 3'd1;
    localparam logic [2:0]  funct_csrrs    = 3'd2;
    localparam logic [2:0]  cmderr_none    = 3'd0;
    localparam logic [2:0]  cmderr_notsup  = 3'd2;
    localparam logic [2:0]  aarsize_32     = 3'd2;
    localparam logic [15:0] regno_last_gpr = 16'h101F;

    // Only a transferring command can be malformed; a pure postexec ignores size and regno.
    function automatic logic cmd_illegal(input dbg_cmd_type c);
        return c.transfer && ((c.aarsize != aarsize_32) || (c.regno > regno_last_gpr));
    endfunction

    function automatic logic [2:0] xfer_words(input logic transfer, input logic is_gpr);
        logic [2:0] n;
        if (!transfer) begin
            n = 3'd0;
        end else if (is_gpr) begin
            n = 3'd1;
        end else begin
            n = 3'd4;
        end
        return n;
    endfunction

    function automatic logic [2:0] words_total(input dbg_cmd_type c);
        logic [2:0] n;
        if (cmd_illegal(c)) begin
            n = 3'd0;
        end else begin
            n = xfer_words(c.transfer, c.regno[15:12] == 4'h1) + (c.postexec ? 3'd0 : 3'd1);
        end
        return n;
    endfunction

endpackage

// File: rtl/dbg_instr_encoder_csr_instr_encode.sv
// Combinational packer for a single RV32 Zicsr instruction word.
module csr_instr_encode
    import dbg_instr_encoder_pkg::*;
(
    input  logic [11:0] csr,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    output logic [31:0] word
);

    assign word = {csr, rs1, funct3, rd, opcode_system};

endmodule

// File: rtl/dbg_instr_encoder.sv
// Abstract-command sequencer: expands one access-register command into csrrw/csrrs
// words (plus a closing ebreak) for the core's debug instruction-injection port.
module dbg_instr_encoder
    import dbg_instr_encoder_pkg::*;
#(
    parameter logic [11:0] DSCRATCH0 = csr_dscratch0,
    parameter logic [11:0] DSCRATCH1 = csr_dscratch1,
    parameter logic [4:0]  TMP_REG   = tmp_gpr
)(
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_regno,
    input  logic        cmd_write,
    input  logic        cmd_transfer,
    input  logic        cmd_postexec,
    input  logic [2:0]  cmd_aarsize,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_word,
    output logic        done,
    output logic [2:0]  cmderr,
    output logic        progbuf_start,
    output logic        busy
);

    enc_state_type state_r;
    dbg_cmd_type   cmd_r;
    logic [2:0]    step_r;
    logic          instr_valid_r;
    logic [31:0]   instr_word_r;
    logic          done_r;
    logic [2:0]    cmderr_r;
    logic          progbuf_start_r;
    logic          busy_r;

    dbg_cmd_type   cmd_in_s;
    logic          in_illegal_s;
    logic [2:0]    in_total_s;
    logic [2:0]    cmd_total_s;
    logic [15:0]   sel_regno_s;
    logic          sel_write_s;
    logic          sel_transfer_s;
    logic [2:0]    sel_step_s;
    logic          sel_gpr_s;
    logic          is_ebreak_s;
    logic [11:0]   enc_csr_s;
    logic [4:0]    enc_rs1_s;
    logic [4:0]    enc_rd_s;
    logic [2:0]    enc_funct3_s;
    logic [31:0]   enc_word_s;
    logic [31:0]   next_word_s;

    assign cmd_in_s     = '{regno: cmd_regno, write: cmd_write, transfer: cmd_transfer,
                            postexec: cmd_postexec, aarsize: cmd_aarsize};
    assign in_illegal_s = cmd_illegal(cmd_in_s);
    assign in_total_s   = words_total(cmd_in_s);
    assign cmd_total_s  = words_total(cmd_r);
    assign cmd_ready    = (state_r == IDLE);

    // In IDLE the encoder looks at the offered command so word 0 is ready at acceptance.
    always_comb begin
        sel_regno_s    = cmd_r.regno;
        sel_write_s    = cmd_r.write;
        sel_transfer_s = cmd_r.transfer;
        sel_step_s     = step_r + 3'd1;
        if (state_r == IDLE) begin
            sel_regno_s    = cmd_in_s.regno;
            sel_write_s    = cmd_in_s.write;
            sel_transfer_s = cmd_in_s.transfer;
            sel_step_s     = 3'd0;
        end else begin
            sel_step_s     = step_r + 3'd1;
        end
    end

    assign sel_gpr_s   = (sel_regno_s[15:12] == 4'h1);
    assign is_ebreak_s = (sel_step_s >= xfer_words(sel_transfer_s, sel_gpr_s));

    // Step-indexed operand mux; CSR accesses bounce through TMP_REG saved in DSCRATCH1.
    always_comb begin
        enc_csr_s    = DSCRATCH1;
        enc_rs1_s    = TMP_REG;
        enc_rd_s     = 5'd0;
        enc_funct3_s = funct_csrrw;
        if (sel_gpr_s) begin
            enc_csr_s = DSCRATCH0;
            if (sel_write_s) begin
                enc_rs1_s    = 5'd0;
                enc_rd_s     = sel_regno_s[4:0];
                enc_funct3_s = funct_csrrs;
            end else begin
                enc_rs1_s    = sel_regno_s[4:0];
                enc_rd_s     = 5'd0;
                enc_funct3_s = funct_csrrw;
            end
        end else begin
            case ({sel_write_s, sel_step_s[1:0]})
                3'b000, 3'b100: begin
                    enc_csr_s = DSCRATCH1; enc_rs1_s = TMP_REG; enc_rd_s = 5'd0;    enc_funct3_s = funct_csrrw;
                end
                3'b001: begin
                    enc_csr_s = sel_regno_s[11:0]; enc_rs1_s = 5'd0; enc_rd_s = TMP_REG; enc_funct3_s = funct_csrrs;
                end
                3'b010: begin
                    enc_csr_s = DSCRATCH0; enc_rs1_s = TMP_REG; enc_rd_s = 5'd0;    enc_funct3_s = funct_csrrw;
                end
                3'b101: begin
                    enc_csr_s = DSCRATCH0; enc_rs1_s = 5'd0;    enc_rd_s = TMP_REG; enc_funct3_s = funct_csrrs;
                end
                3'b110: begin
                    enc_csr_s = sel_regno_s[11:0]; enc_rs1_s = TMP_REG; enc_rd_s = 5'd0; enc_funct3_s = funct_csrrw;
                end
                3'b011, 3'b111: begin
                    enc_csr_s = DSCRATCH1; enc_rs1_s = 5'd0;    enc_rd_s = TMP_REG; enc_funct3_s = funct_csrrs;
                end
                default: begin
                    enc_csr_s = DSCRATCH1; enc_rs1_s = TMP_REG; enc_rd_s = 5'd0;    enc_funct3_s = funct_csrrw;
                end
            endcase
        end
    end

    csr_instr_encode u_encode (
        .csr    (enc_csr_s),
        .rs1    (enc_rs1_s),
        .rd     (enc_rd_s),
        .funct3 (enc_funct3_s),
        .word   (enc_word_s)
    );

    assign next_word_s = is_ebreak_s ? ebreak_instr : enc_word_s;

    // Sequencer: accept, emit words under valid/ready, then one FIN cycle carrying done.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r         <= IDLE;
            cmd_r           <= '0;
            step_r          <= 3'd0;
            instr_valid_r   <= 1'b0;
            instr_word_r    <= 32'd0;
            done_r          <= 1'b0;
            cmderr_r        <= cmderr_none;
            progbuf_start_r <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_r  <= cmd_in_s;
                        step_r <= 3'd0;
                        busy_r <= 1'b1;
                        if (in_illegal_s) begin
                            done_r   <= 1'b1;
                            cmderr_r <= cmderr_notsup;
                            state_r  <= FIN;
                        end else if (in_total_s == 3'd0) begin
                            done_r          <= 1'b1;
                            cmderr_r        <= cmderr_none;
                            progbuf_start_r <= cmd_in_s.postexec;
                            state_r         <= FIN;
                        end else begin
                            instr_valid_r <= 1'b1;
                            instr_word_r  <= next_word_s;
                            state_r       <= EMIT;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EMIT: begin
                    if (instr_valid_r && instr_ready) begin
                        if ((step_r + 3'd1) == cmd_total_s) begin
                            instr_valid_r   <= 1'b0;
                            done_r          <= 1'b1;
                            cmderr_r        <= cmderr_none;
                            progbuf_start_r <= cmd_r.postexec;
                            state_r         <= FIN;
                        end else begin
                            step_r       <= step_r + 3'd1;
                            instr_word_r <= next_word_s;
                        end
                    end else begin
                        state_r <= EMIT;
                    end
                end
                FIN: begin
                    done_r          <= 1'b0;
                    cmderr_r        <= cmderr_none;
                    progbuf_start_r <= 1'b0;
                    busy_r          <= 1'b0;
                    state_r         <= IDLE;
                end
                default: begin
                    instr_valid_r   <= 1'b0;
                    done_r          <= 1'b0;
                    cmderr_r        <= cmderr_none;
                    progbuf_start_r <= 1'b0;
                    busy_r          <= 1'b0;
                    state_r         <= IDLE;
                end
            endcase
        end
    end

    assign instr_valid   = instr_valid_r;
    assign instr_word    = instr_word_r;
    assign done          = done_r;
    assign cmderr        = cmderr_r;
    assign progbuf_start = progbuf_start_r;
    assign busy          = busy_r;

endmodule
